// File: rtl/readout_pkg.sv
// Shared types and constants for the stereo frame-buffer readout sequencer.
package readout_pkg;

    // Sequencer states, in the order a dump walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ISSUE,
        WAIT,
        SEND,
        DONE
    } state_t;

    // Buffer select encoding shared by the address path and the stream output.
    localparam logic SEL_LEFT  = 1'b0;
    localparam logic SEL_RIGHT = 1'b1;

endpackage

// File: rtl/bram_word_fetch.sv
// Waits out the BRAM read latency after an address is issued, then captures
// the returned word. capture_out is high in the cycle the word is latched, so
// word_out holds the new data from the following cycle onwards.
module bram_word_fetch #(
    parameter int BRAM_WIDTH   = 48,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_pixel,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [BRAM_WIDTH-1:0] data_in,
    output logic [BRAM_WIDTH-1:0] word_out,
    output logic                  capture_out
);

    localparam int               CNT_W   = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LATENCY = CNT_W'(READ_LATENCY);

    logic [CNT_W-1:0] cnt;

    // The last counting cycle is the one in which the BRAM output is valid.
    assign capture_out = (cnt == CNT_W'(1));

    // Latency counter: load on start, count down to zero and park there.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (start_in) begin
            cnt <= LATENCY;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture register: holds the fetched word until the next capture.
    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            word_out <= '0;
        end else if (capture_out) begin
            word_out <= data_in;
        end
    end

endmodule

// File: rtl/stereo_readout_sequencer.sv
// Dumps the left then the right camera frame buffer, one word at a time,
// onto a valid/ready stream. Waits for both cameras to finish a frame after
// a start request and freezes both buffers' writes for the whole dump.
module stereo_readout_sequencer
    import readout_pkg::*;
#(
    parameter  int BRAM_WIDTH   = 48,
    parameter  int BRAM_DEPTH   = 12800,
    parameter  int READ_LATENCY = 2,
    localparam int ADDR_W       = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk_pixel,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  left_frame_done_in,
    input  logic                  right_frame_done_in,
    output logic                  freeze_out,
    output logic [ADDR_W-1:0]     rd_addr_out,
    input  logic [BRAM_WIDTH-1:0] left_data_in,
    input  logic [BRAM_WIDTH-1:0] right_data_in,
    output logic [BRAM_WIDTH-1:0] data_out,
    output logic                  sel_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_DEPTH - 1);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr, addr_next;
    logic                sel, sel_next;
    logic                left_flag, left_flag_next;
    logic                right_flag, right_flag_next;
    logic                fetch_start;
    logic                capture;
    logic [BRAM_WIDTH-1:0] fetch_data;

    // Both buffers share one address; only the selected one is captured.
    assign fetch_data = (sel == SEL_RIGHT) ? right_data_in : left_data_in;

    bram_word_fetch #(
        .BRAM_WIDTH   (BRAM_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_fetch (
        .clk_pixel   (clk_pixel),
        .rst_in      (rst_in),
        .start_in    (fetch_start),
        .data_in     (fetch_data),
        .word_out    (data_out),
        .capture_out (capture)
    );

    // State register, read address, buffer select and sticky frame flags.
    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            addr       <= '0;
            sel        <= SEL_LEFT;
            left_flag  <= 1'b0;
            right_flag <= 1'b0;
        end else begin
            state      <= state_next;
            addr       <= addr_next;
            sel        <= sel_next;
            left_flag  <= left_flag_next;
            right_flag <= right_flag_next;
        end
    end

    // Next-state logic. Flags only accumulate while armed; the dump begins on
    // the same edge the second frame-done pulse is seen.
    // NOTE: every variable gets a default before the case so no path through
    // the block leaves one unassigned, which would infer a latch.
    always_comb begin
        state_next      = state;
        addr_next       = addr;
        sel_next        = sel;
        left_flag_next  = 1'b0;
        right_flag_next = 1'b0;
        fetch_start     = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                left_flag_next  = left_flag | left_frame_done_in;
                right_flag_next = right_flag | right_frame_done_in;
                if (left_flag_next && right_flag_next) begin
                    state_next = ISSUE;
                    addr_next  = '0;
                    sel_next   = SEL_LEFT;
                end
            end
            ISSUE: begin
                fetch_start = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (capture) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (ready_in) begin
                    if (addr != LAST_ADDR) begin
                        addr_next  = addr + 1'b1;
                        state_next = ISSUE;
                    end else if (sel == SEL_LEFT) begin
                        sel_next   = SEL_RIGHT;
                        addr_next  = '0;
                        state_next = ISSUE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_addr_out = addr;
    assign sel_out     = sel;
    assign valid_out   = (state == SEND);
    assign busy_out    = (state != IDLE);
    assign done_out    = (state == DONE);
    assign freeze_out  = (state == ISSUE) || (state == WAIT) || (state == SEND);

endmodule

// File: tb/tb_stereo_readout_sequencer.sv
// Randomised bench for stereo_readout_sequencer with small behavioural BRAMs
// and a queue-based model of the expected word stream.
module tb_stereo_readout_sequencer;

    localparam int W      = 48;
    localparam int DEPTH  = 4;
    localparam int RL     = 2;
    localparam int ADDR_W = $clog2(DEPTH);

    logic            clk_pixel = 1'b0;
    logic            rst_in = 1'b1;
    logic            start_in = 1'b0;
    logic            left_frame_done_in = 1'b0;
    logic            right_frame_done_in = 1'b0;
    logic            freeze_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [W-1:0]    left_data_in;
    logic [W-1:0]    right_data_in;
    logic [W-1:0]    data_out;
    logic            sel_out;
    logic            valid_out;
    logic            ready_in = 1'b1;
    logic            busy_out;
    logic            done_out;

    stereo_readout_sequencer #(
        .BRAM_WIDTH   (W),
        .BRAM_DEPTH   (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk_pixel           (clk_pixel),
        .rst_in              (rst_in),
        .start_in            (start_in),
        .left_frame_done_in  (left_frame_done_in),
        .right_frame_done_in (right_frame_done_in),
        .freeze_out          (freeze_out),
        .rd_addr_out         (rd_addr_out),
        .left_data_in        (left_data_in),
        .right_data_in       (right_data_in),
        .data_out            (data_out),
        .sel_out             (sel_out),
        .valid_out           (valid_out),
        .ready_in            (ready_in),
        .busy_out            (busy_out),
        .done_out            (done_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Behavioural BRAMs with a two-stage registered read path.
    logic [W-1:0] left_mem  [DEPTH];
    logic [W-1:0] right_mem [DEPTH];
    logic [W-1:0] l_p1, l_p2, r_p1, r_p2;

    always @(posedge clk_pixel) begin
        l_p1 <= left_mem[rd_addr_out];
        l_p2 <= l_p1;
        r_p1 <= right_mem[rd_addr_out];
        r_p2 <= r_p1;
    end
    assign left_data_in  = l_p2;
    assign right_data_in = r_p2;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected stream: every word the dump still owes, in order.
    typedef struct {
        logic         sel;
        logic [W-1:0] data;
    } word_t;

    word_t exp_q[$];
    int    cyc       = 0;
    int    last_acc  = -1;
    int    done_cnt  = 0;
    int    acc_cnt   = 0;
    bit    acc_prev  = 1'b0;
    bit    spacing_on = 1'b0;

    // Stream monitor, sampling on the falling edge.
    always @(negedge clk_pixel) begin
        cyc++;
        if (acc_prev) check("valid_after_accept", valid_out, 0);
        acc_prev = 1'b0;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid_out, 0);
            end else begin
                check("data", data_out, exp_q[0].data);
                check("sel", sel_out, exp_q[0].sel);
                check("freeze_in_send", freeze_out, 1);
                if (ready_in) begin
                    if (spacing_on && last_acc >= 0) check("spacing", cyc - last_acc, 4);
                    last_acc = cyc;
                    void'(exp_q.pop_front());
                    acc_prev = 1'b1;
                    acc_cnt++;
                end
            end
        end
        if (done_out) begin
            check("done_timing", cyc - last_acc, 1);
            check("done_all_words", exp_q.size(), 0);
            check("freeze_in_done", freeze_out, 0);
            done_cnt++;
            last_acc = -1;
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic load_mems(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            if (rnd) begin
                left_mem[i]  = {$urandom(), $urandom()};
                right_mem[i] = {$urandom(), $urandom()};
            end else begin
                left_mem[i]  = W'(32'h10 + i);
                right_mem[i] = W'(32'h20 + i);
            end
        end
    endtask

    // A full dump is the left buffer in address order, then the right.
    task automatic push_expect();
        word_t w;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w.sel  = (s == 1);
                w.data = (s == 1) ? right_mem[a] : left_mem[a];
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("busy_after_start", busy_out, 1);
        check("freeze_in_arm", freeze_out, 0);
    endtask

    // Deliver both frame-done pulses, gap cycles apart (0 = same cycle).
    task automatic fire_frames(input int gap);
        push_expect();
        last_acc = -1;
        if (gap == 0) begin
            left_frame_done_in  = 1'b1;
            right_frame_done_in = 1'b1;
            tick();
            left_frame_done_in  = 1'b0;
            right_frame_done_in = 1'b0;
        end else begin
            left_frame_done_in = 1'b1;
            tick();
            left_frame_done_in = 1'b0;
            repeat (gap - 1) tick();
            check("freeze_before_right", freeze_out, 0);
            right_frame_done_in = 1'b1;
            tick();
            right_frame_done_in = 1'b0;
        end
        check("freeze_rise", freeze_out, 1);
    endtask

    task automatic wait_done(input bit rnd_ready, input int mid_start_at);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 600) begin
            ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start_in = (n == mid_start_at);
            tick();
            n++;
        end
        start_in = 1'b0;
        ready_in = 1'b1;
        repeat (12) tick();
        check("done_count", done_cnt - d0, 1);
        check("idle_busy", busy_out, 0);
        check("idle_freeze", freeze_out, 0);
        check("idle_valid", valid_out, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_freeze"}, freeze_out, 0);
        check({tag, "_addr"}, rd_addr_out, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_sel"}, sel_out, 0);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_done"}, done_out, 0);
    endtask

    initial begin
        int a0;
        int n;

        load_mems(1'b0);
        tick();
        tick();
        check_all_zero("reset");
        rst_in = 1'b0;
        tick();

        // Frame-done pulses before any start must not launch a dump.
        left_frame_done_in  = 1'b1;
        right_frame_done_in = 1'b1;
        tick();
        left_frame_done_in  = 1'b0;
        right_frame_done_in = 1'b0;
        repeat (10) tick();
        check("idle_pulses_busy", busy_out, 0);
        check("idle_pulses_done", done_cnt, 0);

        // Directed dump: left done, right done five cycles later, ready high.
        spacing_on = 1'b1;
        pulse_start();
        fire_frames(5);
        wait_done(1'b0, -1);

        // Simultaneous frame-done, random ready, second start mid-dump.
        spacing_on = 1'b0;
        load_mems(1'b1);
        pulse_start();
        fire_frames(0);
        wait_done(1'b1, 10);

        // Reset after the third accepted word, then a clean dump from address 0.
        load_mems(1'b0);
        spacing_on = 1'b1;
        pulse_start();
        fire_frames(1);
        a0 = acc_cnt;
        n  = 0;
        while (acc_cnt - a0 < 3 && n < 200) begin
            tick();
            n++;
        end
        check("third_word_reached", acc_cnt - a0 >= 3, 1);
        rst_in = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        last_acc = -1;
        tick();
        rst_in = 1'b0;
        tick();
        check("after_reset_idle", busy_out, 0);
        pulse_start();
        fire_frames(2);
        wait_done(1'b0, -1);

        // Randomised dumps: random contents, pulse spacing and back-pressure.
        spacing_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load_mems(1'b1);
            repeat ($urandom_range(0, 3)) tick();
            pulse_start();
            fire_frames(int'($urandom_range(0, 4)));
            wait_done(1'b1, int'($urandom_range(0, 40)));
        end

        check("total_dumps", done_cnt, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
